branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequences control-flow redirects in the RV32I pipeline. It samples the EX-stage branch/jump resolution (branch_taken, branch_target, jump target) and drives a redirect handshake to fetch. It flushes the IF/ID stages for a fixed number of cycles and holds EX until the redirect completes. It also flags misaligned targets so the trap logic can take over.

Parameters:
XLEN, 32, datapath/address width
FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high after fetch accepts the redirect (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
ex_valid  input  1  EX stage holds a valid instruction
ex_is_branch  input  1  EX instruction is a conditional branch (opcode BRANCH)
ex_is_jump  input  1  EX instruction is JAL/JALR
branch_taken  input  1  branch condition result from the branch generator
branch_target  input  XLEN  pc + B-immediate from the branch generator
jump_target  input  XLEN  JAL/JALR target from the ALU
stall_in  input  1  memory/pipeline stall; EX is frozen this cycle
fetch_ready  input  1  fetch accepts the redirect this cycle
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  XLEN  new fetch PC; stable while redirect_valid is high
flush_if  output  1  squash the IF/ID register
flush_id  output  1  squash the ID/EX register
hold_ex  output  1  freeze EX; no new resolution is presented
misalign_trap  output  1  one-cycle pulse: target[1:0] != 0
branch_count  output  32  resolved conditional branches (stats)
taken_count  output  32  taken conditional branches (stats)

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on rising clk.
- Reset: state=IDLE. redirect_valid, flush_if, flush_id, hold_ex and misalign_trap are 0. redirect_pc=0. Stats counters are 0.
- All outputs are registered.
- Event: ex_valid && !stall_in && state==IDLE && (ex_is_jump || (ex_is_branch && branch_taken)).
- Target selection: jump_target if ex_is_jump, else branch_target. Jump has priority when both flags are set.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE, event with target[1:0] != 0:
  - misalign_trap is high for exactly one cycle, the cycle after the event.
  - No redirect and no flush; stay in IDLE.
- IDLE, event with aligned target:
  - Latch redirect_pc and go to REDIRECT.
  - From the next cycle: redirect_valid=1, hold_ex=1, flush_if=1, flush_id=1.
- IDLE, no event: all control outputs are 0.
- REDIRECT:
  - Hold redirect_valid and redirect_pc stable until fetch_ready=1.
  - On fetch_ready, load cnt=FLUSH_CYCLES-1 and go to FLUSH. redirect_valid drops the next cycle.
  - stall_in has no effect in this state.
- FLUSH:
  - flush_if=1, flush_id=1, hold_ex=1.
  - If cnt==0 go to IDLE, else decrement cnt.
  - All outputs are 0 the cycle after leaving FLUSH.
- Timing, event at cycle N with fetch_ready held high:
  - N+1: redirect_valid=1.
  - N+2 .. N+1+FLUSH_CYCLES: FLUSH.
  - Total flush-high time is FLUSH_CYCLES+1 cycles.
- Events while not in IDLE are ignored. hold_ex guarantees EX is not advancing.
- Not-taken branch, or stall_in=1: no state change and no outputs.
- Reset asserted mid-REDIRECT or mid-FLUSH: the next cycle is IDLE with all outputs 0. No partial redirect remains.
- cnt is 4 bits wide. FLUSH_CYCLES outside 1..15 is a configuration error, caught by an elaboration check.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - branch_count increments on every ex_valid && !stall_in && ex_is_branch cycle in IDLE.
  - taken_count increments when that branch is also taken, aligned or not.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: branch_count and taken_count are tied to 0 and no counter flops are inferred. The port list is unchanged.

Decomposition:
- defines.vh: FSM state encodings (ST_IDLE=2'd0, ST_REDIRECT=2'd1, ST_FLUSH=2'd2) and the default FLUSH_CYCLES constant. Reuse the existing OPCODE_BRANCH/F3_* defines; add none.
- One sub-module: sat_counter, a 32-bit saturating incrementer with sync clear. It is instantiated twice under BRANCH_STATS_EN.

Test Plan:
- Reset, then a taken BEQ at cycle 5 with branch_target=0x0000_0100 and fetch_ready=1: redirect_valid=1 at cycle 6 with redirect_pc=0x100. flush_if/flush_id are high at cycles 6–8 and low at cycle 9.
- Taken branch with fetch_ready=0 for 4 cycles: redirect_valid and redirect_pc=0x200 stay stable and hold_ex=1 throughout. FLUSH begins the cycle after fetch_ready rises.
- ex_is_jump=1, ex_is_branch=1, jump_target=0x300, branch_target=0x400: redirect_pc=0x300.
- Taken branch with branch_target=0x102: misalign_trap pulses for 1 cycle and redirect_valid/flush_if stay 0.
- Taken branch with stall_in=1: no response. A second taken branch during FLUSH is ignored. rst pulsed during REDIRECT: all outputs are 0 the next cycle.
- BRANCH_STATS_EN: 3 taken plus 2 not-taken branches give branch_count=5 and taken_count=3. With taken_count preloaded near saturation (0xFFFF_FFFF via force), it holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
// Holds the FSM state encoding, default parameter values and a target
// alignment helper used by the top level.
package branch_redirect_ctrl_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned STAT_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // RV32I without compressed instructions needs word-aligned targets
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake between the redirect controller and fetch.
//   redirect_valid : redirect request to fetch
//   redirect_pc    : new fetch PC, stable while redirect_valid is high
//   fetch_ready    : fetch accepts the redirect this cycle
// master = redirect controller, slave = fetch.
interface branch_redirect_ctrl_if
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_ready;

  modport master (output redirect_valid, output redirect_pc, input fetch_ready);
  modport slave  (input redirect_valid, input redirect_pc, output fetch_ready);
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   clr   : synchronous clear, active high
//   inc   : increment request
//   count : current value, sticks at all-ones
module branch_redirect_ctrl_sat_counter
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned W = STAT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect sequencer for the RV32I pipeline.
// Samples EX branch/jump resolution, issues a redirect to fetch, flushes
// IF/ID while holding EX, and flags misaligned targets for trap handling.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ex_valid/ex_is_branch/ex_is_jump/branch_taken : EX resolution info
//   branch_target, jump_target   : candidate targets
//   stall_in                     : EX frozen this cycle
//   fetch (master)               : redirect_valid/redirect_pc/fetch_ready
//   flush_if, flush_id, hold_ex  : pipeline control
//   misalign_trap                : one-cycle misaligned-target pulse
//   branch_count, taken_count    : statistics (BRANCH_STATS_EN macro)
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       branch_target,
  input  logic [XLEN-1:0]       jump_target,
  input  logic                  stall_in,
  branch_redirect_ctrl_if.master fetch,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  hold_ex,
  output logic                  misalign_trap,
  output logic [STAT_W-1:0]     branch_count,
  output logic [STAT_W-1:0]     taken_count
);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
    $error("branch_redirect_ctrl: FLUSH_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             rv_q, rv_d;
  logic             flush_q, flush_d;
  logic             hold_q, hold_d;
  logic             trap_q, trap_d;
  logic [XLEN-1:0]  target;
  logic             resolve;

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rv_d    = 1'b0;
    flush_d = 1'b0;
    hold_d  = 1'b0;
    trap_d  = 1'b0;
    target  = ex_is_jump ? jump_target : branch_target;
    resolve = ex_valid && !stall_in && (ex_is_jump || (ex_is_branch && branch_taken));

    unique case (state_q)
      ST_IDLE: begin
        if (resolve) begin
          if (is_misaligned(target[1:0])) begin
            trap_d = 1'b1;
          end else begin
            state_d = ST_REDIRECT;
            pc_d    = target;
            rv_d    = 1'b1;
            flush_d = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      ST_REDIRECT: begin
        flush_d = 1'b1;
        hold_d  = 1'b1;
        if (fetch.fetch_ready) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end else begin
          rv_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Outputs drop together with the return to IDLE
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
          hold_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      rv_q    <= 1'b0;
      flush_q <= 1'b0;
      hold_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rv_q    <= rv_d;
      flush_q <= flush_d;
      hold_q  <= hold_d;
      trap_q  <= trap_d;
    end
  end

  assign fetch.redirect_valid = rv_q;
  assign fetch.redirect_pc    = pc_q;
  assign flush_if             = flush_q;
  assign flush_id             = flush_q;
  assign hold_ex              = hold_q;
  assign misalign_trap        = trap_q;

`ifdef BRANCH_STATS_EN
  logic branch_seen;
  logic taken_seen;

  // Only IDLE-state branches are new resolutions; others are held in EX
  assign branch_seen = ex_valid && !stall_in && ex_is_branch && (state_q == ST_IDLE);
  assign taken_seen  = branch_seen && branch_taken;

  branch_redirect_ctrl_sat_counter #(.W(STAT_W)) u_branch_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (branch_seen),
    .count (branch_count)
  );

  branch_redirect_ctrl_sat_counter #(.W(STAT_W)) u_taken_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (taken_seen),
    .count (taken_count)
  );
`else
  assign branch_count = '0;
  assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a behavioural model pushes
// the expected post-edge outputs onto a scoreboard queue as each cycle of
// stimulus is driven; the entry is popped and compared after the edge.
module tb_branch_redirect_ctrl;

  localparam int unsigned FLUSH_CYCLES = 2;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        trap;
    logic [31:0] bc;
    logic [31:0] tc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jump, branch_taken, stall_in;
  logic [31:0] branch_target, jump_target;
  logic        flush_if, flush_id, hold_ex, misalign_trap;
  logic [31:0] branch_count, taken_count;

  branch_redirect_ctrl_if #(.XLEN(32)) fetch_bus ();

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jump    (ex_is_jump),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall_in      (stall_in),
    .fetch         (fetch_bus),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .hold_ex       (hold_ex),
    .misalign_trap (misalign_trap),
    .branch_count  (branch_count),
    .taken_count   (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  exp_t        sb[$];

  // Reference model: mode 0 idle, 1 waiting for fetch, 2 flushing
  int          m_mode = 0;
  int          m_left = 0;
  logic [31:0] m_pc   = '0;
  logic [31:0] m_br   = '0;
  logic [31:0] m_tk   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic r, input logic v, input logic b, input logic j,
                      input logic t, input logic [31:0] bt, input logic [31:0] jt,
                      input logic st, input logic fr);
    exp_t        e;
    exp_t        got;
    logic [31:0] tgt;
    logic        ev;
    @(negedge clk);
    rst = r; ex_valid = v; ex_is_branch = b; ex_is_jump = j; branch_taken = t;
    branch_target = bt; jump_target = jt; stall_in = st; fetch_bus.fetch_ready = fr;
    e.trap = 1'b0;
    if (r) begin
      m_mode = 0; m_left = 0; m_pc = '0; m_br = '0; m_tk = '0;
    end else begin
      if (m_mode == 0 && v && !st && b) begin
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (t && m_tk != 32'hFFFF_FFFF) m_tk = m_tk + 1;
      end
      case (m_mode)
        0: begin
          tgt = j ? jt : bt;
          ev  = v && !st && (j || (b && t));
          if (ev) begin
            if (tgt[1:0] != 2'b00) e.trap = 1'b1;
            else begin m_mode = 1; m_pc = tgt; end
          end
        end
        1: if (fr) begin m_mode = 2; m_left = FLUSH_CYCLES; end
        default: begin m_left--; if (m_left == 0) m_mode = 0; end
      endcase
    end
    e.rv = (m_mode == 1);
    e.pc = m_pc;
    e.fl = (m_mode != 0);
    e.bc = STATS ? m_br : 32'd0;
    e.tc = STATS ? m_tk : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sb.pop_front();
    check("redirect_valid", 32'(fetch_bus.redirect_valid), 32'(got.rv));
    check("redirect_pc", fetch_bus.redirect_pc, got.pc);
    check("flush_if", 32'(flush_if), 32'(got.fl));
    check("flush_id", 32'(flush_id), 32'(got.fl));
    check("hold_ex", 32'(hold_ex), 32'(got.fl));
    check("misalign_trap", 32'(misalign_trap), 32'(got.trap));
    check("branch_count", branch_count, got.bc);
    check("taken_count", taken_count, got.tc);
  endtask

  task automatic idle(input int n, input logic fr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, fr);
  endtask

  task automatic taken_br(input logic [31:0] bt, input logic fr);
    step(0, 1, 1, 0, 1, bt, 32'h0, 0, fr);
  endtask

  int flush_hi;

  initial begin
    rst = 1'b1; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; branch_taken = 0;
    branch_target = '0; jump_target = '0; stall_in = 0; fetch_bus.fetch_ready = 0;

    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("reset_rv", 32'(fetch_bus.redirect_valid), 32'd0);
    check("reset_pc", fetch_bus.redirect_pc, 32'd0);
    idle(2, 1);

    // Taken branch with fetch ready: flush for FLUSH_CYCLES+1 cycles
    taken_br(32'h0000_0100, 1);
    check("tp1_rv", 32'(fetch_bus.redirect_valid), 32'd1);
    check("tp1_pc", fetch_bus.redirect_pc, 32'h100);
    flush_hi = 1;
    for (int i = 0; i < 5; i++) begin
      idle(1, 1);
      if (flush_if) flush_hi++;
    end
    check("tp1_flush_len", 32'(flush_hi), 32'(FLUSH_CYCLES + 1));

    // Fetch back-pressure: redirect held stable
    taken_br(32'h0000_0200, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 0);
      check("bp_pc", fetch_bus.redirect_pc, 32'h200);
      check("bp_hold", 32'(hold_ex), 32'd1);
    end
    idle(6, 1);

    // Jump has priority over branch target
    step(0, 1, 1, 1, 1, 32'h0000_0400, 32'h0000_0300, 0, 1);
    check("jump_prio_pc", fetch_bus.redirect_pc, 32'h300);
    idle(5, 1);

    // Misaligned branch target: trap only
    taken_br(32'h0000_0102, 1);
    check("misalign_trap_pulse", 32'(misalign_trap), 32'd1);
    idle(2, 1);
    // Misaligned jump target wins over aligned branch target
    step(0, 1, 1, 1, 1, 32'h0000_0500, 32'h0000_0301, 0, 1);
    idle(2, 1);

    // Stalled, not-taken and invalid resolutions are ignored
    step(0, 1, 1, 0, 1, 32'h0000_0600, 32'h0, 1, 1);
    step(0, 1, 1, 0, 0, 32'h0000_0600, 32'h0, 0, 1);
    step(0, 0, 0, 1, 0, 32'h0, 32'h0000_0700, 0, 1);
    idle(1, 1);

    // Second taken branch during FLUSH is ignored
    taken_br(32'h0000_0800, 1);
    idle(1, 1);
    taken_br(32'h0000_0900, 1);
    check("ignored_pc", fetch_bus.redirect_pc, 32'h800);
    idle(4, 1);

    // Reset during REDIRECT clears everything
    taken_br(32'h0000_0A00, 0);
    idle(1, 0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("rst_mid_rv", 32'(fetch_bus.redirect_valid), 32'd0);
    check("rst_mid_flush", 32'(flush_if), 32'd0);
    idle(3, 1);

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      logic [31:0] bt;
      logic [31:0] jt;
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) jt[1:0] = 2'($urandom_range(1, 3));
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), bt, jt,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
    end

    // Statistics: 3 taken + 2 not-taken branches after reset
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      taken_br(32'h0000_1000 + 32'(i * 16), 1);
      idle(4, 1);
    end
    step(0, 1, 1, 0, 0, 32'h0000_2000, 32'h0, 0, 1);
    step(0, 1, 1, 0, 0, 32'h0000_2000, 32'h0, 0, 1);
    check("stats_branch", branch_count, STATS ? 32'd5 : 32'd0);
    check("stats_taken", taken_count, STATS ? 32'd3 : 32'd0);

`ifdef BRANCH_STATS_EN
    // Saturation of the taken counter
    @(negedge clk);
    force dut.u_taken_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_taken_cnt.count;
    m_tk = 32'hFFFF_FFFF;
    taken_br(32'h0000_3000, 1);
    idle(4, 1);
    check("stats_taken_sat", taken_count, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
